// File: rtl/conv1_weight_loader_if.sv
// rtl/conv1_weight_loader_if.sv - weight FIFO and PE bank handshake bundle for conv1_weight_loader
interface conv1_weight_loader_if #(
    parameter int DATA_WIDTH = 64,
    parameter int BANK_BITS  = 1728,
    parameter int IDX_W      = 2
);
    logic                  i_start;
    logic                  o_weight_ready;
    logic                  i_weight_valid;
    logic [DATA_WIDTH-1:0] i_weight_data;
    logic                  o_load_w_finish;
    logic                  o_bank_valid;
    logic [BANK_BITS-1:0]  o_bank_weights;
    logic [IDX_W-1:0]      o_group_idx;
    logic                  i_group_done;

    modport master (
        output i_start, i_weight_valid, i_weight_data, i_group_done,
        input  o_weight_ready, o_load_w_finish, o_bank_valid, o_bank_weights, o_group_idx
    );

    modport slave (
        input  i_start, i_weight_valid, i_weight_data, i_group_done,
        output o_weight_ready, o_load_w_finish, o_bank_valid, o_bank_weights, o_group_idx
    );
endinterface

// File: rtl/conv1_weight_loader.sv
// rtl/conv1_weight_loader.sv - unpacks FIFO weight words into ping-pong kernel banks for the conv1 PE array
module conv1_weight_loader #(
    parameter int DATA_WIDTH   = 64,
    parameter int W_WIDTH      = 8,
    parameter int IN_CH        = 3,
    parameter int K_SIZE       = 9,
    parameter int OC_GROUP     = 8,
    parameter int TOTAL_GROUPS = 4
) (
    input  logic s_clk,
    input  logic s_rst,
    conv1_weight_loader_if.slave bus
);
    localparam int BANK_W = OC_GROUP * IN_CH * K_SIZE;
    localparam int WORDS  = BANK_W * W_WIDTH / DATA_WIDTH;
    localparam int CNT_W  = $clog2(WORDS + 1);
    localparam int GIDX_W = $clog2(TOTAL_GROUPS);

    localparam logic [CNT_W-1:0]  WORDS_C   = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [GIDX_W-1:0] LAST_GRP  = GIDX_W'(TOTAL_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, FIN} state_t;

    state_t             state, state_next;
    logic               rvalid_d;
    logic [CNT_W-1:0]   req_cnt, rcv_cnt;
    logic [GIDX_W-1:0]  grp_cnt, rd_grp;
    logic               wr_sel, rd_sel;
    logic [1:0]         full;
    logic               take, complete, release_bank;
    logic               ready, finish;

    logic [DATA_WIDTH-1:0] bank [2][WORDS];

    assign take         = bus.i_weight_valid && (state == LOAD);
    assign complete     = rvalid_d && (rcv_cnt == LAST_WORD);
    assign release_bank = bus.i_group_done && full[rd_sel];

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (bus.i_start) state_next = LOAD;
            LOAD: begin
                ready = (req_cnt < WORDS_C) && !full[wr_sel];
                if (complete) state_next = (grp_cnt == LAST_GRP) ? FIN : WAIT;
            end
            // wr_sel already points at the next bank; resume once the PE frees it
            WAIT: if (!full[wr_sel]) state_next = LOAD;
            FIN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            rvalid_d <= 1'b0;
            req_cnt  <= '0;
            rcv_cnt  <= '0;
            grp_cnt  <= '0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            rd_grp   <= '0;
            full     <= 2'b00;
        end else begin
            rvalid_d <= take;
            if (complete) begin
                req_cnt <= '0;
                rcv_cnt <= '0;
                wr_sel  <= ~wr_sel;
                grp_cnt <= (grp_cnt == LAST_GRP) ? '0 : grp_cnt + 1'b1;
            end else begin
                if (take)     req_cnt <= req_cnt + 1'b1;
                if (rvalid_d) rcv_cnt <= rcv_cnt + 1'b1;
            end
            // completion and release always target opposite banks, so both apply
            if (release_bank) begin
                full[rd_sel] <= 1'b0;
                rd_sel       <= ~rd_sel;
                rd_grp       <= (rd_grp == LAST_GRP) ? '0 : rd_grp + 1'b1;
            end
            if (complete) full[wr_sel] <= 1'b1;
        end
    end

    always_ff @(posedge s_clk) begin
        if (rvalid_d) bank[wr_sel][rcv_cnt] <= bus.i_weight_data;
    end

    // Byte b of word k is weight k*8+b, so the flat bus is just the words laid end to end.
    always_comb begin
        bus.o_bank_weights = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (full[rd_sel]) bus.o_bank_weights[k*DATA_WIDTH +: DATA_WIDTH] = bank[rd_sel][k];
        end
    end

    assign bus.o_weight_ready  = ready;
    assign bus.o_load_w_finish = finish;
    assign bus.o_bank_valid    = full[rd_sel];
    assign bus.o_group_idx     = rd_grp;
endmodule

// File: tb/tb_conv1_weight_loader.sv
// tb/tb_conv1_weight_loader.sv - directed self-checking bench for conv1_weight_loader
module tb_conv1_weight_loader;
    logic s_clk = 1'b0;
    logic s_rst = 1'b1;

    conv1_weight_loader_if #(.DATA_WIDTH(64), .BANK_BITS(1728), .IDX_W(2)) bus ();

    conv1_weight_loader dut (
        .s_clk (s_clk),
        .s_rst (s_rst),
        .bus   (bus.slave)
    );

    always #5 s_clk = ~s_clk;

    int n_checks = 0;
    int n_fail   = 0;

    int issued, done_count, finish_cnt, pe_cnt, valid_pct;
    bit fifo_en, pe_en, done_at_54, manual_fired;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model and PE model, both driving on the falling edge
    initial begin
        bus.i_start        = 1'b0;
        bus.i_weight_valid = 1'b0;
        bus.i_weight_data  = '0;
        bus.i_group_done   = 1'b0;
        forever begin
            bit landed, do_done;
            logic [7:0] v;
            int bad;
            @(negedge s_clk);
            landed = 1'b0;
            if (bus.i_weight_valid) begin
                v = 8'(issued);
                bus.i_weight_data = {8{v}};
                issued++;
                landed = 1'b1;
            end
            bus.i_weight_valid = fifo_en && bus.o_weight_ready && ($urandom_range(0, 99) < valid_pct);
            if (bus.o_load_w_finish) finish_cnt++;

            bus.i_group_done = 1'b0;
            do_done = 1'b0;
            if (pe_en && bus.o_bank_valid) begin
                if (pe_cnt == 4) begin
                    do_done = 1'b1;
                    pe_cnt  = 0;
                end else pe_cnt++;
            end else pe_cnt = 0;
            if (done_at_54 && landed && issued == 54 && !manual_fired) begin
                do_done      = 1'b1;
                manual_fired = 1'b1;
            end
            if (do_done) begin
                bad = 0;
                for (int k = 0; k < 27; k++) begin
                    v = 8'(done_count * 27 + k);
                    if (bus.o_bank_weights[k*64 +: 64] !== {8{v}}) bad++;
                end
                check_eq("bank_data", 64'(bad), 64'd0);
                check_eq("group_idx", 64'(bus.o_group_idx), 64'(done_count % 4));
                bus.i_group_done = 1'b1;
                done_count++;
            end
        end
    end

    task automatic do_reset();
        s_rst = 1'b1;
        repeat (3) @(posedge s_clk);
        #1;
        issued = 0; done_count = 0; finish_cnt = 0; pe_cnt = 0;
        manual_fired = 1'b0;
        s_rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge s_clk);
        bus.i_start = 1'b1;
        @(negedge s_clk);
        bus.i_start = 1'b0;
    endtask

    task automatic run_to_finish(input string tag);
        for (int i = 0; i < 4000 && finish_cnt == 0; i++) @(posedge s_clk);
        for (int i = 0; i < 200 && bus.o_bank_valid; i++) @(posedge s_clk);
        repeat (5) @(posedge s_clk);
        #1;
        check_eq({tag, "_finish"}, 64'(finish_cnt), 64'd1);
        check_eq({tag, "_words"},  64'(issued), 64'd108);
        check_eq({tag, "_groups"}, 64'(done_count), 64'd4);
        check_eq({tag, "_ready"},  64'(bus.o_weight_ready), 64'd0);
        check_eq({tag, "_idx"},    64'(bus.o_group_idx), 64'd0);
    endtask

    initial begin
        fifo_en = 1'b1; pe_en = 1'b0; done_at_54 = 1'b0; valid_pct = 100;
        issued = 0; done_count = 0; finish_cnt = 0; pe_cnt = 0; manual_fired = 1'b0;
        do_reset();
        check_eq("rst_ready",   64'(bus.o_weight_ready), 64'd0);
        check_eq("rst_finish",  64'(bus.o_load_w_finish), 64'd0);
        check_eq("rst_bvalid",  64'(bus.o_bank_valid), 64'd0);
        check_eq("rst_idx",     64'(bus.o_group_idx), 64'd0);
        check_eq("rst_weights", 64'(bus.o_bank_weights != '0), 64'd0);

        // first bank fills, PE never releases
        pulse_start();
        for (int i = 0; i < 200 && !bus.o_bank_valid; i++) @(posedge s_clk);
        #1;
        check_eq("t1_bvalid", 64'(bus.o_bank_valid), 64'd1);
        check_eq("t1_words",  64'(issued), 64'd27);
        check_eq("t1_w215",   64'(bus.o_bank_weights[215*8 +: 8]), 64'd26);
        check_eq("t1_w0",     64'(bus.o_bank_weights[7:0]), 64'd0);
        check_eq("t1_idx",    64'(bus.o_group_idx), 64'd0);
        repeat (200) @(posedge s_clk);
        #1;
        check_eq("t2_words",  64'(issued), 64'd54);
        check_eq("t2_ready",  64'(bus.o_weight_ready), 64'd0);
        check_eq("t2_bvalid", 64'(bus.o_bank_valid), 64'd1);
        check_eq("t2_idx",    64'(bus.o_group_idx), 64'd0);
        check_eq("t2_w215",   64'(bus.o_bank_weights[215*8 +: 8]), 64'd26);

        // full load with an always-ready upstream
        pe_en = 1'b1;
        do_reset();
        pulse_start();
        run_to_finish("t3");

        // same load with a stalling upstream
        valid_pct = 50;
        do_reset();
        pulse_start();
        run_to_finish("t4");

        // release of bank 0 lands on the cycle bank 1 completes
        valid_pct = 100; pe_en = 1'b0; done_at_54 = 1'b1;
        do_reset();
        pulse_start();
        for (int i = 0; i < 500 && !manual_fired; i++) @(posedge s_clk);
        #1;
        check_eq("t5_fired",  64'(manual_fired), 64'd1);
        check_eq("t5_bvalid", 64'(bus.o_bank_valid), 64'd1);
        check_eq("t5_idx",    64'(bus.o_group_idx), 64'd1);
        check_eq("t5_w0",     64'(bus.o_bank_weights[7:0]), 64'd27);
        @(posedge s_clk);
        #1;
        check_eq("t5_resume", 64'(bus.o_weight_ready), 64'd1);
        pe_en = 1'b1; done_at_54 = 1'b0;
        run_to_finish("t5");

        // asynchronous reset in the middle of group 2, then a clean reload
        do_reset();
        pulse_start();
        for (int i = 0; i < 1000 && issued < 64; i++) @(posedge s_clk);
        #2;
        s_rst = 1'b1;
        #1;
        check_eq("t6_ready",   64'(bus.o_weight_ready), 64'd0);
        check_eq("t6_bvalid",  64'(bus.o_bank_valid), 64'd0);
        check_eq("t6_idx",     64'(bus.o_group_idx), 64'd0);
        check_eq("t6_weights", 64'(bus.o_bank_weights != '0), 64'd0);
        do_reset();
        repeat (3) @(posedge s_clk);
        #1;
        check_eq("t6_idle", 64'(bus.o_weight_ready), 64'd0);
        pulse_start();
        run_to_finish("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
